mips_alu: RTL and testbench



---
 rtl/mips_alu_pkg.sv | 24 ++
 rtl/mips_alu_mul.sv | 17 +
 rtl/mips_alu.sv | 117 +++++++++++
 tb/tb_mips_alu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared constants for the EX-stage ALU: datapath width and the ALU_Control encodings
// that the control unit drives.
package mips_alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_ADDU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_MULT  = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_LUI   = 4'b1110;
  localparam logic [3:0] ALU_SUBU  = 4'b1111;

endpackage

// File: rtl/mips_alu_mul.sv
// Combinational 32x32 -> 64 multiplier; is_signed selects MULT versus MULTU semantics.
module mips_alu_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] product
);

  logic [63:0] a_wide;
  logic [63:0] b_wide;

  // The low 64 bits of a product of extended operands are exact for both signednesses.
  assign a_wide  = {{32{a[31] & is_signed}}, a};
  assign b_wide  = {{32{b[31] & is_signed}}, b};
  assign product = a_wide * b_wide;

endmodule

// File: rtl/mips_alu.sv
// Registered 32-bit MIPS ALU with flags and HI/LO; the multiplier is built only when
// MIPS_ALU_MULT_EN is defined, otherwise MULT/MULTU yield zero and HI/LO stay cleared.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Control,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Zero,
  output logic             Overflow,
  output logic             Signed,
  output logic             valid
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] result_next;
  logic             ovf_next;
  logic             hilo_we;

  assign sum   = A + B;
  assign diff  = A - B;
  assign shamt = A[4:0];

`ifdef MIPS_ALU_MULT_EN
  logic [63:0] product;

  mips_alu_mul u_mul (
    .a         (A),
    .b         (B),
    .is_signed (ALU_Control == ALU_MULT),
    .product   (product)
  );
`endif

  always_comb begin
    result_next = '0;
    ovf_next    = 1'b0;
    hilo_we     = 1'b0;
    case (ALU_Control)
      ALU_AND:  result_next = A & B;
      ALU_OR:   result_next = A | B;
      ALU_ADD: begin
        result_next = sum;
        ovf_next    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_ADDU: result_next = sum;
      ALU_XOR:  result_next = A ^ B;
      ALU_NOR:  result_next = ~(A | B);
      ALU_SUB: begin
        result_next = diff;
        ovf_next    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:  result_next = B << shamt;
      ALU_SRL:  result_next = B >> shamt;
      ALU_SRA:  result_next = $signed(B) >>> shamt;
      ALU_MULT, ALU_MULTU: begin
`ifdef MIPS_ALU_MULT_EN
        result_next = product[31:0];
        hilo_we     = 1'b1;
`else
        result_next = '0;
        hilo_we     = 1'b0;
`endif
      end
      ALU_LUI:  result_next = {B[15:0], 16'h0000};
      ALU_SUBU: result_next = diff;
      default:  result_next = '0;
    endcase
  end

  // Zero/Signed come from the value being written so they always match ALU_Result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_Result <= '0;
      Zero       <= 1'b1;
      Overflow   <= 1'b0;
      Signed     <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        ALU_Result <= result_next;
        Zero       <= (result_next == '0);
        Overflow   <= ovf_next;
        Signed     <= result_next[WIDTH-1];
      end
    end
  end

`ifdef MIPS_ALU_MULT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (en && hilo_we) begin
      Hi <= product[63:32];
      Lo <= product[31:0];
    end
  end
`else
  assign Hi = '0;
  assign Lo = '0;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Table-driven scoreboard bench for mips_alu; multiply expectations follow MIPS_ALU_MULT_EN.
module tb_mips_alu;
  import mips_alu_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Control;
  logic [31:0] ALU_Result;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Zero;
  logic        Overflow;
  logic        Signed;
  logic        valid;

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  vec_t mul_tbl[$];

  mips_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .A           (A),
    .B           (B),
    .ALU_Control (ALU_Control),
    .ALU_Result  (ALU_Result),
    .Hi          (Hi),
    .Lo          (Lo),
    .Zero        (Zero),
    .Overflow    (Overflow),
    .Signed      (Signed),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic [3:0] ctrl, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic ovf, logic [31:0] hi, logic [31:0] lo);
    vec_t v;
    v.name = name; v.ctrl = ctrl; v.a = a; v.b = b;
    v.res = res; v.ovf = ovf; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic checkOutput(vec_t e);
    cmp({e.name, ".result"},   ALU_Result, e.res);
    cmp({e.name, ".zero"},     {31'b0, Zero}, {31'b0, (e.res == 32'h0)});
    cmp({e.name, ".signed"},   {31'b0, Signed}, {31'b0, e.res[31]});
    cmp({e.name, ".overflow"}, {31'b0, Overflow}, {31'b0, e.ovf});
    cmp({e.name, ".hi"},       Hi, e.hi);
    cmp({e.name, ".lo"},       Lo, e.lo);
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    A = v.a; B = v.b; ALU_Control = v.ctrl; en = 1'b1;
    exp_q.push_back(v);
  endtask

  task automatic drain(string name);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cmp({name, ".queue_left"}, exp_q.size(), 0);
  endtask

  task automatic checkResetState(string name);
    cmp({name, ".result"},   ALU_Result, 32'h0);
    cmp({name, ".hi"},       Hi, 32'h0);
    cmp({name, ".lo"},       Lo, 32'h0);
    cmp({name, ".zero"},     {31'b0, Zero}, 32'h1);
    cmp({name, ".overflow"}, {31'b0, Overflow}, 32'h0);
    cmp({name, ".signed"},   {31'b0, Signed}, 32'h0);
    cmp({name, ".valid"},    {31'b0, valid}, 32'h0);
  endtask

  // Scoreboard monitor: every valid pulse must correspond to a queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_valid: got valid=1 with result %h, want no output", ALU_Result);
        end else begin
          checkOutput(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] mh1, ml1, mh2, ml2, mres;

`ifdef MIPS_ALU_MULT_EN
    mh1 = 32'hFFFF_FFFF; ml1 = 32'hFFFF_FFFA;
    mh2 = 32'h0000_0002; ml2 = 32'hFFFF_FFFA;
    mres = 32'hFFFF_FFFA;
`else
    mh1 = 32'h0; ml1 = 32'h0; mh2 = 32'h0; ml2 = 32'h0; mres = 32'h0;
`endif

    tbl.push_back(mk("add_5_7",     ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 0, 0));
    tbl.push_back(mk("add_ovf",     ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 0, 0));
    tbl.push_back(mk("addu_noovf",  ALU_ADDU, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 0, 0));
    tbl.push_back(mk("add_negovf",  ALU_ADD,  32'h80000000, 32'h80000000, 32'h0,        1'b1, 0, 0));
    tbl.push_back(mk("sub_ovf",     ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 0, 0));
    tbl.push_back(mk("sub_plain",   ALU_SUB,  32'd5,        32'd3,        32'd2,        1'b0, 0, 0));
    tbl.push_back(mk("subu_wrap",   ALU_SUBU, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 0, 0));
    tbl.push_back(mk("slt",         ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 0, 0));
    tbl.push_back(mk("sltu",        ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 0, 0));
    tbl.push_back(mk("sra",         ALU_SRA,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 0, 0));
    tbl.push_back(mk("srl",         ALU_SRL,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 0, 0));
    tbl.push_back(mk("sll",         ALU_SLL,  32'hFFFFFFE4, 32'h1,        32'h10,       1'b0, 0, 0));
    tbl.push_back(mk("lui",         ALU_LUI,  32'hDEADBEEF, 32'h00001234, 32'h12340000, 1'b0, 0, 0));
    tbl.push_back(mk("nor",         ALU_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 0, 0));
    tbl.push_back(mk("or",          ALU_OR,   32'hF0,       32'h0F,       32'hFF,       1'b0, 0, 0));
    tbl.push_back(mk("xor",         ALU_XOR,  32'hFF,       32'h0F,       32'hF0,       1'b0, 0, 0));
    tbl.push_back(mk("and",         ALU_AND,  32'hF0,       32'h3C,       32'h30,       1'b0, 0, 0));

    mul_tbl.push_back(mk("mult",     ALU_MULT,  32'hFFFFFFFE, 32'd3, mres,  1'b0, mh1, ml1));
    mul_tbl.push_back(mk("multu",    ALU_MULTU, 32'hFFFFFFFE, 32'd3, mres,  1'b0, mh2, ml2));
    mul_tbl.push_back(mk("and_keep", ALU_AND,   32'hFFFFFFFE, 32'd3, 32'h2, 1'b0, mh2, ml2));

    reset = 1'b1; en = 1'b0; A = '0; B = '0; ALU_Control = ALU_AND;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) applyStimulus(tbl[i]);
    drain("table");

    // SUB to zero, then outputs must hold through idle cycles with changing inputs.
    applyStimulus(mk("sub_zero", ALU_SUB, 32'd9, 32'd9, 32'h0, 1'b0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      A = $urandom; B = $urandom; ALU_Control = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      cmp($sformatf("hold%0d.result", k), ALU_Result, 32'h0);
      cmp($sformatf("hold%0d.zero", k), {31'b0, Zero}, 32'h1);
      cmp($sformatf("hold%0d.valid", k), {31'b0, valid}, 32'h0);
    end
    drain("hold");

    foreach (mul_tbl[i]) applyStimulus(mul_tbl[i]);
    drain("mul");

    // Reset together with en: the capture is discarded and everything clears.
    @(negedge clk);
    A = 32'd1; B = 32'd2; ALU_Control = ALU_ADD; en = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midreset");
    @(negedge clk);
    reset = 1'b0; en = 1'b0;

    applyStimulus(mk("post_reset_add", ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 0, 0));
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
